io_in_sched: RTL

//  Input-side sample scheduler for a proc_fx core. Buffers NUIOIN independent source

---
 rtl/io_in_sched_pkg.sv | 26 ++
 rtl/io_in_sched_fifo.sv | 75 +++++++
 rtl/io_in_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/io_in_sched_pkg.sv
// io_in_sched_pkg
//   Shared definitions for the input-side sample scheduler: the scheduler
//   state encoding and an integer ceiling-log2 helper used to size the FIFO
//   pointers and level outputs.
package io_in_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_e;

    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_in_sched_fifo.sv
// io_fifo
//   Single-channel sample FIFO with a combinational head output.
//   Ports:
//     clk, rst  clock and asynchronous active-low reset
//     push      write din when not full (a full FIFO ignores push, even if popped)
//     pop       advance the head when not empty
//     flush     empty the FIFO at the next edge; overrides push and pop
//     din       write data
//     dout      current head word
//     full      DEPTH entries stored
//     empty     no entries stored
//     level     occupancy, 0..DEPTH
module io_fifo
    import io_in_sched_pkg::*;
#(
    parameter  int NUBITS = 32,
    parameter  int DEPTH  = 8,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [NUBITS-1:0] din,
    output logic [NUBITS-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [NUBITS-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    // Pointers carry an extra wrap bit: equal pointers mean empty, equal
    // address bits with differing wrap bits mean full.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_in_sched.sv
// io_in_sched
//   Input-side sample scheduler for a proc_fx core. Buffers NUIOIN source
//   streams in per-channel FIFOs, serves the core's one-hot input reads from
//   the selected FIFO head, holds the core disabled until every channel has
//   at least THRESH words, and freezes it on an underflow.
//   Ports:
//     clk, rst    clock and asynchronous active-low reset
//     enable      run request; dropping it aborts and flushes
//     clr_err     pulse that leaves ERR (flush, clear flags, refill)
//     src_data    channel k at [k*NUBITS +: NUBITS]
//     src_valid   per-channel source valid
//     src_ready   per-channel ready (!full in FILL/RUN)
//     req_in      one-hot read strobe from addr_dec
//     io_in       selected head word (0 when nothing valid is selected)
//     proc_en     core run enable
//     udf         sticky per-channel underflow flag
//     multi_req   sticky flag for a multi-bit req_in seen in RUN
//     level       per-channel occupancy, AW+1 bits each
module io_in_sched
    import io_in_sched_pkg::*;
#(
    parameter  int NUBITS = 32,
    parameter  int NUIOIN = 2,
    parameter  int DEPTH  = 8,
    parameter  int THRESH = 1,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clr_err,
    input  logic [NUIOIN*NUBITS-1:0]   src_data,
    input  logic [NUIOIN-1:0]          src_valid,
    output logic [NUIOIN-1:0]          src_ready,
    input  logic [NUIOIN-1:0]          req_in,
    output logic signed [NUBITS-1:0]   io_in,
    output logic                       proc_en,
    output logic [NUIOIN-1:0]          udf,
    output logic                       multi_req,
    output logic [NUIOIN*(AW+1)-1:0]   level
);

    localparam logic [AW:0] THRESH_LVL = (AW+1)'(THRESH);

    state_e            state_q, state_d;
    logic              proc_en_q, proc_en_d;
    logic [NUIOIN-1:0] udf_q, udf_d;
    logic              multi_q, multi_d;

    logic [NUBITS-1:0] head [NUIOIN];
    logic [AW:0]       lvl  [NUIOIN];
    logic [NUIOIN-1:0] full, empty, push, pop;
    logic [NUIOIN-1:0] sel_oh;
    logic              req_any, req_multi, sel_empty, all_primed, flush;
    logic              accepting, running;

    assign running   = (state_q == RUN);
    assign accepting = (state_q == FILL) || running;
    assign flush     = !enable || ((state_q == ERR) && clr_err);
    assign src_ready = accepting ? ~full : '0;
    assign push      = src_valid & src_ready;
    assign pop       = running ? (sel_oh & ~empty) : '0;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_ch
        io_fifo #(
            .NUBITS (NUBITS),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (pop[k]),
            .flush (flush),
            .din   (src_data[k*NUBITS +: NUBITS]),
            .dout  (head[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .level (lvl[k])
        );
        assign level[k*(AW+1) +: AW+1] = lvl[k];
    end

    // Lowest-index set bit of req_in wins.
    always_comb begin
        logic found;
        sel_oh = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUIOIN; i++) begin
            if (req_in[i] && !found) begin
                sel_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign req_any   = |req_in;
    assign req_multi = |(req_in & ~sel_oh);
    assign sel_empty = |(sel_oh & empty);

    // An empty selected FIFO drives 0: there is no bypass from src_data.
    always_comb begin
        io_in = '0;
        for (int unsigned i = 0; i < NUIOIN; i++) begin
            if (sel_oh[i] && !empty[i]) io_in = head[i];
        end
    end

    always_comb begin
        all_primed = 1'b1;
        for (int unsigned i = 0; i < NUIOIN; i++) begin
            if (lvl[i] < THRESH_LVL) all_primed = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        udf_d   = udf_q;
        multi_d = multi_q;
        case (state_q)
            IDLE: if (enable) state_d = FILL;
            FILL: if (all_primed) state_d = RUN;
            RUN: begin
                if (req_any) begin
                    if (req_multi) multi_d = 1'b1;
                    if (sel_empty) begin
                        udf_d   = udf_q | sel_oh;
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                if (clr_err) begin
                    udf_d   = '0;
                    multi_d = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            udf_d   = '0;
            multi_d = 1'b0;
        end
        proc_en_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            proc_en_q <= 1'b0;
            udf_q     <= '0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            proc_en_q <= proc_en_d;
            udf_q     <= udf_d;
            multi_q   <= multi_d;
        end
    end

    assign proc_en   = proc_en_q;
    assign udf       = udf_q;
    assign multi_req = multi_q;

endmodule
